// File: rtl/bcd_addsub_pkg.sv
// Shared types and constants for the signed 3-digit BCD add/subtract stage.
// Holds the FSM state encoding, the BCD digit limit and the sign codes.
package bcd_addsub_pkg;

    localparam logic [3:0] BCD_MAX  = 4'd9;
    localparam logic       SIGN_POS = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CAPTURE = 3'd1,
        ST_COMPARE = 3'd2,
        ST_DIG0    = 3'd3,
        ST_DIG1    = 3'd4,
        ST_DIG2    = 3'd5,
        ST_FINISH  = 3'd6
    } state_t;

    typedef struct packed {
        logic       sign;
        logic [3:0] huns;
        logic [3:0] tens;
        logic [3:0] ones;
    } bcd3_t;

    function automatic logic [3:0] pick_digit(input bcd3_t v, input logic [1:0] idx);
        case (idx)
            2'd1:    return v.tens;
            2'd2:    return v.huns;
            default: return v.ones;
        endcase
    endfunction

    function automatic logic has_bad_digit(input bcd3_t v);
        return (v.huns > BCD_MAX) || (v.tens > BCD_MAX) || (v.ones > BCD_MAX);
    endfunction

endpackage

// File: rtl/bcd_addsub_digit.sv
// Single BCD digit adder/subtractor with carry/borrow chaining.
// Shared across the three digit cycles of the top-level sequencer.
module bcd_digit_addsub
    import bcd_addsub_pkg::*;
(
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic       cin,
    input  logic       sub,
    output logic [3:0] d,
    output logic       cout
);

    logic [4:0] sum;
    logic [4:0] adj;
    logic [4:0] diff;

    always_comb begin
        sum  = {1'b0, x} + {1'b0, y} + {4'b0, cin};
        adj  = sum - 5'd10;
        diff = {1'b0, x} - {1'b0, y} - {4'b0, cin};
        d    = sum[3:0];
        cout = 1'b0;
        if (sub) begin
            // diff[4] flags a negative digit; +10 mod 16 recovers the BCD digit
            if (diff[4]) begin
                d    = diff[3:0] + 4'd10;
                cout = 1'b1;
            end else begin
                d = diff[3:0];
            end
        end else if (sum > {1'b0, BCD_MAX}) begin
            d    = adj[3:0];
            cout = 1'b1;
        end
    end

endmodule

// File: rtl/bcd_addsub.sv
// Sequential signed BCD add/subtract: resynchronises load, captures two signed
// 3-digit operands and produces a signed 4-digit result one digit per cycle.
module bcd_addsub
    import bcd_addsub_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic       op,
    input  logic [3:0] a_ones,
    input  logic [3:0] a_tens,
    input  logic [3:0] a_huns,
    input  logic       a_sign,
    input  logic [3:0] b_ones,
    input  logic [3:0] b_tens,
    input  logic [3:0] b_huns,
    input  logic       b_sign,
    output logic [3:0] res_ones,
    output logic [3:0] res_tens,
    output logic [3:0] res_huns,
    output logic       res_thou,
    output logic       res_sign,
    output logic       busy,
    output logic       done,
    output logic       err
);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   prev_reg;
    logic                   start_evt;

    state_t          state_reg;
    bcd3_t           a_reg;
    bcd3_t           b_reg;
    logic            op_reg;
    logic            eff_sub_reg;
    logic            a_ge_b_reg;
    logic            carry_reg;
    logic [2:0][3:0] sum_reg;

    bcd3_t      a_in;
    bcd3_t      b_in;
    logic [1:0] dig_idx;
    logic       swap;
    logic [3:0] x_dig;
    logic [3:0] y_dig;
    logic [3:0] dig_out;
    logic       dig_cout;
    logic       thou_next;
    logic       mag_zero;
    logic       sign_calc;

    assign a_in = {a_sign, a_huns, a_tens, a_ones};
    assign b_in = {b_sign, b_huns, b_tens, b_ones};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg <= '0;
            prev_reg <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], load};
            prev_reg <= sync_reg[SYNC_STAGES-1];
        end
    end

    assign start_evt = sync_reg[SYNC_STAGES-1] & ~prev_reg;

    always_comb begin
        case (state_reg)
            ST_DIG1: dig_idx = 2'd1;
            ST_DIG2: dig_idx = 2'd2;
            default: dig_idx = 2'd0;
        endcase
    end

    // Subtraction always runs larger-minus-smaller, so swap when |B| > |A|
    assign swap  = eff_sub_reg & ~a_ge_b_reg;
    assign x_dig = swap ? pick_digit(b_reg, dig_idx) : pick_digit(a_reg, dig_idx);
    assign y_dig = swap ? pick_digit(a_reg, dig_idx) : pick_digit(b_reg, dig_idx);

    bcd_digit_addsub u_digit (
        .x    (x_dig),
        .y    (y_dig),
        .cin  (carry_reg),
        .sub  (eff_sub_reg),
        .d    (dig_out),
        .cout (dig_cout)
    );

    assign thou_next = ~eff_sub_reg & carry_reg;
    assign mag_zero  = (sum_reg == '0) && !thou_next;
    assign sign_calc = eff_sub_reg ? (a_ge_b_reg ? a_reg.sign : (b_reg.sign ^ op_reg))
                                   : a_reg.sign;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            a_reg       <= '0;
            b_reg       <= '0;
            op_reg      <= 1'b0;
            eff_sub_reg <= 1'b0;
            a_ge_b_reg  <= 1'b0;
            carry_reg   <= 1'b0;
            sum_reg     <= '0;
            res_ones    <= '0;
            res_tens    <= '0;
            res_huns    <= '0;
            res_thou    <= 1'b0;
            res_sign    <= SIGN_POS;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (start_evt) begin
                        state_reg <= ST_CAPTURE;
                        busy      <= 1'b1;
                    end
                end
                ST_CAPTURE: begin
                    a_reg       <= a_in;
                    b_reg       <= b_in;
                    op_reg      <= op;
                    eff_sub_reg <= a_sign ^ b_sign ^ op;
                    carry_reg   <= 1'b0;
                    err         <= 1'b0;
                    if (has_bad_digit(a_in) || has_bad_digit(b_in)) begin
                        err       <= 1'b1;
                        res_ones  <= '0;
                        res_tens  <= '0;
                        res_huns  <= '0;
                        res_thou  <= 1'b0;
                        res_sign  <= SIGN_POS;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        state_reg <= ST_FINISH;
                    end else begin
                        state_reg <= ST_COMPARE;
                    end
                end
                ST_COMPARE: begin
                    // Packed BCD compares like binary when every digit is <= 9
                    a_ge_b_reg <= ({a_reg.huns, a_reg.tens, a_reg.ones} >=
                                   {b_reg.huns, b_reg.tens, b_reg.ones});
                    carry_reg  <= 1'b0;
                    state_reg  <= ST_DIG0;
                end
                ST_DIG0, ST_DIG1, ST_DIG2: begin
                    sum_reg[dig_idx] <= dig_out;
                    carry_reg        <= dig_cout;
                    state_reg        <= (state_reg == ST_DIG0) ? ST_DIG1 :
                                        (state_reg == ST_DIG1) ? ST_DIG2 : ST_FINISH;
                end
                ST_FINISH: begin
                    // busy is already low here on the error path, whose outputs were set in CAPTURE
                    if (busy) begin
                        res_ones <= sum_reg[0];
                        res_tens <= sum_reg[1];
                        res_huns <= sum_reg[2];
                        res_thou <= thou_next;
                        res_sign <= mag_zero ? SIGN_POS : sign_calc;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                    end
                    state_reg <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule
